cic_decim_prog: RTL

Parametrised, runtime-programmable CIC decimator. It replaces the fixed 5-stage, fixed-ratio CIC in the receiver chain. It adds:
- a generate-based stage count
- an input valid strobe
- a runtime decimation ratio, latched per output frame
- differential delay M of 1 or 2
- a pipelined comb section
- output saturation with a sticky overflow flag

It sits between the 1-bit/NCO mixer output and the audio low-pass/AGC stage.

---
 rtl/cic_decim_prog.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/cic_decim_prog.sv
// Runtime-programmable CIC decimator: STAGES integrators at the input rate, a
// valid-tagged pipelined comb section, gain shift and saturating output.
module cic_decim_prog #(
  parameter int STAGES     = 5,
  parameter int WIDTH      = 81,
  parameter int BITS       = 16,
  parameter int OUT_BITS   = 16,
  parameter int DECIM_BITS = 16,
  parameter int GAIN_BITS  = 8,
  parameter int M          = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [BITS-1:0]       x_in,
  input  logic                  in_valid,
  input  logic [DECIM_BITS-1:0] decim,
  input  logic [GAIN_BITS-1:0]  gain,
  input  logic                  clr_ovf,
  output logic [OUT_BITS-1:0]   x_out,
  output logic                  out_tick,
  output logic                  overflow
);

  localparam logic [DECIM_BITS-1:0] DEC_ZERO = {DECIM_BITS{1'b0}};
  localparam logic [DECIM_BITS-1:0] DEC_ONE  = {{(DECIM_BITS-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]      ACC_ZERO = {WIDTH{1'b0}};
  localparam logic [OUT_BITS-1:0]   OUT_ZERO = {OUT_BITS{1'b0}};
  localparam logic [OUT_BITS-1:0]   OUT_MAX  = {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic [OUT_BITS-1:0]   OUT_MIN  = {1'b1, {(OUT_BITS-1){1'b0}}};
  localparam logic [31:0]           HEADROOM = 32'(WIDTH - OUT_BITS);

  // Slot 0 of each chain is the stage input; slot k is the output of stage k.
  logic [(STAGES+1)*WIDTH-1:0] integ_chain_s;
  logic [(STAGES+1)*WIDTH-1:0] comb_chain_s;
  logic [STAGES:0]             comb_v_s;

  logic [DECIM_BITS-1:0] decim_eff_s;
  logic                  capture_s;

  assign integ_chain_s[0 +: WIDTH] = {{(WIDTH-BITS){x_in[BITS-1]}}, x_in};
  assign decim_eff_s = (decim == DEC_ZERO) ? DEC_ONE : decim;

  for (genvar k = 0; k < STAGES; k++) begin : g_integ
    logic [WIDTH-1:0] integ_q;
    logic [WIDTH-1:0] integ_d;

    // Integrator k accumulates the previous stage (wraps at WIDTH by design).
    always_comb begin
      integ_d = integ_q;
      if (in_valid) begin
        integ_d = integ_q + integ_chain_s[k*WIDTH +: WIDTH];
      end else begin
        integ_d = integ_q;
      end
    end

    // Integrator state register.
    always_ff @(posedge CLK) begin
      if (RST) begin
        integ_q <= ACC_ZERO;
      end else begin
        integ_q <= integ_d;
      end
    end

    assign integ_chain_s[(k+1)*WIDTH +: WIDTH] = integ_q;
  end

  logic [DECIM_BITS-1:0] cnt_q, cnt_d;
  logic [DECIM_BITS-1:0] r_act_q, r_act_d;
  logic [WIDTH-1:0]      c0_q, c0_d;
  logic                  v0_q, v0_d;

  // Frame counter; the ratio is re-latched only on the capture edge.
  always_comb begin
    cnt_d     = cnt_q;
    r_act_d   = r_act_q;
    capture_s = in_valid && (cnt_q == (r_act_q - DEC_ONE));
    if (capture_s) begin
      cnt_d   = DEC_ZERO;
      r_act_d = decim_eff_s;
    end else if (in_valid) begin
      cnt_d   = cnt_q + DEC_ONE;
    end else begin
      cnt_d   = cnt_q;
    end
  end

  // Comb input register takes the pre-update last integrator on capture.
  always_comb begin
    v0_d = capture_s;
    c0_d = c0_q;
    if (capture_s) begin
      c0_d = integ_chain_s[STAGES*WIDTH +: WIDTH];
    end else begin
      c0_d = c0_q;
    end
  end

  // Counter, latched ratio and comb input registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= DEC_ZERO;
      r_act_q <= decim_eff_s;
      c0_q    <= ACC_ZERO;
      v0_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      r_act_q <= r_act_d;
      c0_q    <= c0_d;
      v0_q    <= v0_d;
    end
  end

  assign comb_chain_s[0 +: WIDTH] = c0_q;
  assign comb_v_s[0]              = v0_q;

  for (genvar k = 1; k <= STAGES; k++) begin : g_comb
    logic [WIDTH-1:0]   prev_c_s;
    logic               prev_v_s;
    logic [WIDTH-1:0]   c_q, c_d;
    logic               v_q, v_d;
    logic [M*WIDTH-1:0] dly_q, dly_d;
    logic [M*WIDTH-1:0] dly_shift_s;

    assign prev_c_s = comb_chain_s[(k-1)*WIDTH +: WIDTH];
    assign prev_v_s = comb_v_s[k-1];

    if (M == 1) begin : g_m1
      assign dly_shift_s = prev_c_s;
    end else begin : g_m2
      assign dly_shift_s = {dly_q[WIDTH-1:0], prev_c_s};
    end

    // Comb k differences against the oldest delay tap, only when its input is valid.
    always_comb begin
      v_d   = prev_v_s;
      c_d   = c_q;
      dly_d = dly_q;
      if (prev_v_s) begin
        c_d   = prev_c_s - dly_q[M*WIDTH-1 -: WIDTH];
        dly_d = dly_shift_s;
      end else begin
        c_d   = c_q;
        dly_d = dly_q;
      end
    end

    // Comb stage and delay line registers.
    always_ff @(posedge CLK) begin
      if (RST) begin
        c_q   <= ACC_ZERO;
        v_q   <= 1'b0;
        dly_q <= {(M*WIDTH){1'b0}};
      end else begin
        c_q   <= c_d;
        v_q   <= v_d;
        dly_q <= dly_d;
      end
    end

    assign comb_chain_s[k*WIDTH +: WIDTH] = c_q;
    assign comb_v_s[k]                    = v_q;
  end

  logic [31:0]         gain_ext_s;
  logic [31:0]         shift_s;
  logic [WIDTH-1:0]    y_s;
  logic                fits_s;
  logic                sat_s;
  logic [OUT_BITS-1:0] x_out_q, x_out_d;
  logic                out_tick_q, out_tick_d;
  logic                overflow_q, overflow_d;

  // Gain shift, range check and saturation; a saturation beats clr_ovf.
  always_comb begin
    gain_ext_s = 32'(gain);
    if (gain_ext_s >= HEADROOM) begin
      shift_s = 32'd0;
    end else begin
      shift_s = HEADROOM - gain_ext_s;
    end
    y_s        = $signed(comb_chain_s[STAGES*WIDTH +: WIDTH]) >>> shift_s;
    fits_s     = (&y_s[WIDTH-1:OUT_BITS-1]) | ~(|y_s[WIDTH-1:OUT_BITS-1]);
    sat_s      = comb_v_s[STAGES] & ~fits_s;
    out_tick_d = comb_v_s[STAGES];
    x_out_d    = x_out_q;
    if (comb_v_s[STAGES]) begin
      if (fits_s) begin
        x_out_d = y_s[OUT_BITS-1:0];
      end else if (y_s[WIDTH-1]) begin
        x_out_d = OUT_MIN;
      end else begin
        x_out_d = OUT_MAX;
      end
    end else begin
      x_out_d = x_out_q;
    end
    overflow_d = overflow_q;
    if (sat_s) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_out_q    <= OUT_ZERO;
      out_tick_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      x_out_q    <= x_out_d;
      out_tick_q <= out_tick_d;
      overflow_q <= overflow_d;
    end
  end

  assign x_out    = x_out_q;
  assign out_tick = out_tick_q;
  assign overflow = overflow_q;

endmodule
